// File: rtl/traffic_countdown_display.sv
// Per-direction countdown of the remaining phase seconds, derived from the traffic
// controller's lamps and shown on a 4-digit multiplexed 7-segment display.
module traffic_countdown_display #(
    parameter int CLK_HZ     = 1000,
    parameter int GREEN_SEC  = 55,
    parameter int YELLOW_SEC = 5,
    parameter int RED_SEC    = 60,
    parameter int SCAN_DIV   = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       en,
    input  logic       R1,
    input  logic       Y1,
    input  logic       G1,
    input  logic       R2,
    input  logic       Y2,
    input  logic       G2,
    output logic [6:0] seg,
    output logic [3:0] dig_sel,
    output logic [7:0] cnt1_bcd,
    output logic [7:0] cnt2_bcd
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [2:0] {
        PH_OFF,
        PH_GREEN,
        PH_YELLOW,
        PH_RED,
        PH_INVALID
    } phase_t;

    logic          r_en;
    logic          r_r1, r_y1, r_g1, r_r2, r_y2, r_g2;
    phase_t        r_ph1, r_ph2;
    logic [7:0]    r_cnt1, r_cnt2;
    logic [PW-1:0] r_presc;
    logic [SW-1:0] r_scanCnt;
    logic [1:0]    r_scanIdx;
    logic [6:0]    r_seg;
    logic [3:0]    r_digSel;

    phase_t        w_ph1, w_ph2;
    logic          w_chg1, w_chg2, w_tick;
    logic [3:0]    w_nibble;
    phase_t        w_digPh;
    logic          w_isTens;
    logic [6:0]    w_segNext;

    function automatic phase_t decode(input logic e, input logic r, input logic y, input logic g);
        if (!e) return PH_OFF;
        case ({r, y, g})
            3'b001:  return PH_GREEN;
            3'b010:  return PH_YELLOW;
            3'b100:  return PH_RED;
            default: return PH_INVALID;
        endcase
    endfunction

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] loadValue(input phase_t p);
        case (p)
            PH_GREEN:  return toBcd(GREEN_SEC);
            PH_YELLOW: return toBcd(YELLOW_SEC);
            PH_RED:    return toBcd(RED_SEC);
            default:   return 8'h00;
        endcase
    endfunction

    function automatic logic isValid(input phase_t p);
        return (p == PH_GREEN) || (p == PH_YELLOW) || (p == PH_RED);
    endfunction

    // BCD decrement that parks at 01 so a held phase never shows 00 or wraps
    function automatic logic [7:0] decBcd(input logic [7:0] c);
        if (c == 8'h01 || c == 8'h00) return c;
        if (c[3:0] == 4'd0) return {c[7:4] - 4'd1, 4'd9};
        return {c[7:4], c[3:0] - 4'd1};
    endfunction

    function automatic logic [6:0] segOf(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    assign w_ph1  = decode(r_en, r_r1, r_y1, r_g1);
    assign w_ph2  = decode(r_en, r_r2, r_y2, r_g2);
    assign w_chg1 = (w_ph1 != r_ph1);
    assign w_chg2 = (w_ph2 != r_ph2);
    assign w_tick = (r_presc == PW'(CLK_HZ - 1));

    always_comb begin
        w_nibble = r_cnt1[3:0];
        w_digPh  = r_ph1;
        w_isTens = 1'b0;
        case (r_scanIdx)
            2'd0: begin
                w_nibble = r_cnt1[3:0];
                w_digPh  = r_ph1;
            end
            2'd1: begin
                w_nibble = r_cnt1[7:4];
                w_digPh  = r_ph1;
                w_isTens = 1'b1;
            end
            2'd2: begin
                w_nibble = r_cnt2[3:0];
                w_digPh  = r_ph2;
            end
            default: begin
                w_nibble = r_cnt2[7:4];
                w_digPh  = r_ph2;
                w_isTens = 1'b1;
            end
        endcase
        // an invalid lamp combination overrides the digits with a dash
        w_segNext = segOf(w_nibble);
        if (w_digPh == PH_INVALID) begin
            w_segNext = 7'b1000000;
        end else if (w_isTens && w_nibble == 4'd0) begin
            w_segNext = 7'b0000000;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_en      <= 1'b0;
            r_r1      <= 1'b0;
            r_y1      <= 1'b0;
            r_g1      <= 1'b0;
            r_r2      <= 1'b0;
            r_y2      <= 1'b0;
            r_g2      <= 1'b0;
            r_ph1     <= PH_OFF;
            r_ph2     <= PH_OFF;
            r_cnt1    <= 8'h00;
            r_cnt2    <= 8'h00;
            r_presc   <= '0;
            r_scanCnt <= '0;
            r_scanIdx <= 2'd0;
            r_seg     <= 7'b0000000;
            r_digSel  <= 4'b0000;
        end else begin
            r_en <= en;
            r_r1 <= R1;
            r_y1 <= Y1;
            r_g1 <= G1;
            r_r2 <= R2;
            r_y2 <= Y2;
            r_g2 <= G2;

            r_ph1 <= w_ph1;
            r_ph2 <= w_ph2;

            // a phase load takes priority over a coincident second tick
            if (w_chg1) begin
                r_cnt1 <= loadValue(w_ph1);
            end else if (w_tick && isValid(w_ph1)) begin
                r_cnt1 <= decBcd(r_cnt1);
            end
            if (w_chg2) begin
                r_cnt2 <= loadValue(w_ph2);
            end else if (w_tick && isValid(w_ph2)) begin
                r_cnt2 <= decBcd(r_cnt2);
            end

            if (w_chg1 || w_chg2 || w_tick) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            // display blanks and the scan position freezes while disabled
            if (r_en) begin
                r_digSel <= 4'b0001 << r_scanIdx;
                r_seg    <= w_segNext;
                if (r_scanCnt == SW'(SCAN_DIV - 1)) begin
                    r_scanCnt <= '0;
                    r_scanIdx <= r_scanIdx + 2'd1;
                end else begin
                    r_scanCnt <= r_scanCnt + 1'b1;
                end
            end else begin
                r_digSel <= 4'b0000;
                r_seg    <= 7'b0000000;
            end
        end
    end

    assign seg      = r_seg;
    assign dig_sel  = r_digSel;
    assign cnt1_bcd = r_cnt1;
    assign cnt2_bcd = r_cnt2;

endmodule

// File: doc/traffic_countdown_display.md
Name: traffic_countdown_display

Overview:
- Downstream stage of the two-direction traffic light controller.
- Consumes the controller's six lamp outputs plus its enable, and tracks the remaining seconds of each direction's current phase.
- Drives a 4-digit multiplexed 7-segment display: direction 1 on digits 0–1, direction 2 on digits 2–3.
- Runs from the same 1 kHz system clock as the controller.

Parameters:
- CLK_HZ, 1000: clock cycles per second tick.
- GREEN_SEC, 55: green phase length in seconds (≤99).
- YELLOW_SEC, 5: yellow phase length in seconds (≤99).
- RED_SEC, 60: red phase length in seconds; equals GREEN_SEC+YELLOW_SEC (≤99).
- SCAN_DIV, 4: clock cycles each digit stays selected (≥1).

Ports:
- Clk  in  1  system clock, 1 kHz.
- Rst  in  1  reset (see interface note below).
- en  in  1  controller enable.
- R1,Y1,G1  in  1 each  direction-1 lamps from the controller.
- R2,Y2,G2  in  1 each  direction-2 lamps from the controller.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high.
- dig_sel  out  4  one-hot digit enable, active-high.
- cnt1_bcd  out  8  direction-1 remaining seconds, BCD {tens,units}.
- cnt2_bcd  out  8  direction-2 remaining seconds, BCD {tens,units}.

Interface note: one clock; reset is synchronous and active-low. Rst=0 on a Clk rising edge resets the block; Rst has priority over en.

Behaviour:
- Reset values: seg=0, dig_sel=0, cnt1_bcd=0, cnt2_bcd=0, scan index=0, prescaler=0, both phase registers=OFF.
- Input stage: en and the six lamps are registered once at each posedge.
- Phase decode, per direction, from the registered lamps:
  - GREEN: G=1, Y=0, R=0.
  - YELLOW: Y=1, G=0, R=0.
  - RED: R=1, G=0, Y=0.
  - INVALID: any other combination.
  - OFF: forced whenever registered en=0.
- Phase register: holds the previous decoded phase per direction.
- Phase change (decoded phase ≠ phase register):
  - Load the count with the phase duration: GREEN_SEC, YELLOW_SEC or RED_SEC, stored in BCD.
  - INVALID and OFF load 00.
  - Latency: a lamp change is visible on cntN_bcd exactly 2 cycles later.
- Prescaler: 0..CLK_HZ-1, shared by both directions.
  - Restarts at 0 on the cycle either direction changes phase.
  - At CLK_HZ-1 it generates a one-cycle tick.
- On tick, per direction with an unchanged valid phase:
  - Decrement the BCD count.
  - Units 0 borrows: units←9, tens←tens-1.
  - Saturate at 01; never reach 00 or wrap.
  - INVALID/OFF counts stay 00.
- Simultaneous tick and phase change on a direction: the load wins.
- Scan: the scan index advances every SCAN_DIV cycles.
  - dig_sel order: 0001 (dir1 units) → 0010 (dir1 tens) → 0100 (dir2 units) → 1000 (dir2 tens) → 0001 ...
  - seg is registered and aligned with dig_sel in the same cycle.
- Segment content:
  - Digits 0–9 use standard encoding.
  - Tens digit 0 is blanked (seg=0).
  - A direction in INVALID shows the dash pattern 7'b1000000 on both of its digits.
- en=0 (registered):
  - dig_sel=0 and seg=0 from the next cycle.
  - Both counts are cleared; the scan index holds.
  - When en returns to 1, both directions reload, because OFF→valid is a phase change.
- Reset mid-operation: all state returns to its reset value on that edge, regardless of the count or scan position.

Test Plan:
- Rst=0 for 10 cycles with random lamps → seg=0, dig_sel=0, cnt1_bcd=cnt2_bcd=8'h00 throughout.
- Rst=1, en=1, R1=1, G2=1 → 2 cycles later cnt1=8'h60, cnt2=8'h55; +1000 cycles → 8'h59/8'h54; +9000 more cycles → 8'h50/8'h45.
- Hold 55000 cycles after the load, then G2→Y2 → cnt1=8'h05, cnt2=8'h05. After 5000 cycles drive G1=1, R2=1 → cnt1=8'h55, cnt2=8'h60.
- Hold green 60 s without a lamp change → count saturates at 8'h01. Value 09 with dig_sel=0010 → seg=0 (tens blanked); dig_sel=0001 → seg=7'b1101111.
- Drive R1=G1=1 → cnt1=8'h00 and the dash pattern on digits 0/1. Deassert en mid-count → dig_sel=0 within 2 cycles. Re-enable with R1/G2 → 8'h60/8'h55.
- SCAN_DIV=4 → dig_sel sequence 0001, 0010, 0100, 1000, each held 4 cycles. Rst=0 mid-scan → dig_sel=0 at the next edge.
